// File: rtl/output_path_pkg.sv
// Shared types for the output path: writer FSM state and default skid-FIFO geometry.
package output_path_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } osw_state_t;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int FIFO_PTR_W         = $clog2(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/osw_sync_fifo.sv
// Registered skid FIFO for the SPAD writer; head is readable combinationally, flush empties it in one cycle.
// Caller must not push when full (unless popping) nor pop when empty.
module osw_sync_fifo
    import output_path_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PTR_W = FIFO_PTR_W
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_nrst && !i_flush && i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/output_spad_writer.sv
// Writes router words into the output SPAD at consecutive addresses from a programmed base, signals done after N commits.
// Optional address bound check: define OUTPUT_SPAD_WRITER_BOUND_CHECK_EN.
module output_spad_writer
    import output_path_pkg::*;
#(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_start,
    input  logic [SPAD_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]       i_word_cnt,
    input  logic [SPAD_DATA_WIDTH-1:0] i_data,
    input  logic                       i_valid,
    input  logic                       i_spad_wr_ready,
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    input  logic [SPAD_ADDR_WIDTH-1:0] i_addr_limit,
    output logic                       o_bound_err,
`endif
    output logic                       o_spad_wr_en,
    output logic [SPAD_ADDR_WIDTH-1:0] o_spad_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overflow
);

    osw_state_t                 r_state;
    logic [SPAD_ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]       r_remaining;
    logic                       r_done;
    logic                       r_overflow;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    logic [SPAD_ADDR_WIDTH-1:0] r_limit;
    logic                       r_bound_err;
`endif

    logic                       w_start_ok;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_last_pop;
    logic                       w_drop;
    logic                       w_flush;
    logic                       w_addr_ok;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [SPAD_DATA_WIDTH-1:0] w_head;

    assign w_start_ok = (r_state == IDLE) && i_start && (i_word_cnt != '0);
    // Gating with i_nrst keeps the strobe low in the reset cycle itself.
    assign w_pop      = i_nrst && (r_state == RUN) && !w_fifo_empty && i_spad_wr_ready;
    assign w_last_pop = w_pop && (r_remaining == CNT_WIDTH'(1));
    assign w_push     = (r_state == RUN) && i_valid && (!w_fifo_full || w_pop);
    assign w_drop     = (r_state == RUN) && i_valid && w_fifo_full && !w_pop;
    assign w_flush    = w_start_ok || w_last_pop;

`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    assign w_addr_ok   = (r_addr <= r_limit);
    assign o_bound_err = r_bound_err;
`else
    assign w_addr_ok   = 1'b1;
`endif

    osw_sync_fifo #(
        .WIDTH (SPAD_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PTR_W ($clog2(FIFO_DEPTH))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_data),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
            r_limit     <= '0;
            r_bound_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_word_cnt == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_addr      <= i_base_addr;
                            r_remaining <= i_word_cnt;
                            r_overflow  <= 1'b0;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
                            r_limit     <= i_addr_limit;
                            r_bound_err <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (w_drop) r_overflow <= 1'b1;
                    if (w_pop) begin
                        r_addr      <= r_addr + SPAD_ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
                        if (!w_addr_ok) r_bound_err <= 1'b1;
`endif
                        if (w_last_pop) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_spad_wr_en = w_pop && w_addr_ok;
    assign o_spad_addr  = o_spad_wr_en ? r_addr : '0;
    assign o_spad_data  = o_spad_wr_en ? w_head : '0;
    assign o_busy       = (r_state == RUN);
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_output_spad_writer.sv
// Bench for output_spad_writer: queue-based reference model checked every cycle plus directed scenario checks.
module tb_output_spad_writer;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          nrst, start, valid, ready;
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    logic [DW-1:0] data;
    logic          wr_en, busy, done, ovf;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    logic [AW-1:0] limit;
    logic          berr;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_run;
    bit            m_done;
    bit            m_ovf;
    logic [AW-1:0] m_addr;
    int            m_rem;
    logic [DW-1:0] m_q[$];
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    logic [AW-1:0] m_limit;
    bit            m_berr;
`endif
    logic [AW+DW-1:0] wlog[$];
    logic [DW-1:0]    d[16];

    always #5 clk = ~clk;

    output_spad_writer #(
        .SPAD_ADDR_WIDTH (AW),
        .SPAD_DATA_WIDTH (DW),
        .CNT_WIDTH       (CW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_nrst          (nrst),
        .i_start         (start),
        .i_base_addr     (base),
        .i_word_cnt      (cnt),
        .i_data          (data),
        .i_valid         (valid),
        .i_spad_wr_ready (ready),
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        .i_addr_limit    (limit),
        .o_bound_err     (berr),
`endif
        .o_spad_wr_en    (wr_en),
        .o_spad_addr     (addr),
        .o_spad_data     (wdata),
        .o_busy          (busy),
        .o_done          (done),
        .o_overflow      (ovf)
    );

    // One clock: compare DUT against the model at negedge, advance the model, return 1ns after posedge.
    task automatic cycle();
        bit            pop, wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        pop = nrst && m_run && (m_q.size() > 0) && ready;
        wr  = pop;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        if (pop && (m_addr > m_limit)) wr = 1'b0;
`endif
        ea = wr ? m_addr : '0;
        ed = wr ? m_q[0] : '0;
        n_vec++;
        if ({wr_en, addr, wdata} !== {wr, ea, ed}) begin
            n_err++;
            $display("FAIL write_port: got en=%b addr=%h data=%h, expected en=%b addr=%h data=%h",
                     wr_en, addr, wdata, wr, ea, ed);
        end
        n_vec++;
        if ({busy, done, ovf} !== {m_run, m_done, m_ovf}) begin
            n_err++;
            $display("FAIL status: got busy=%b done=%b ovf=%b, expected busy=%b done=%b ovf=%b",
                     busy, done, ovf, m_run, m_done, m_ovf);
        end
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        n_vec++;
        if (berr !== m_berr) begin
            n_err++;
            $display("FAIL bound_err: got %b expected %b", berr, m_berr);
        end
`endif
        if (wr_en === 1'b1) wlog.push_back({addr, wdata});

        if (!nrst) begin
            m_run = 0; m_done = 0; m_ovf = 0; m_addr = '0; m_rem = 0; m_q.delete();
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
            m_limit = '0; m_berr = 0;
`endif
        end else if (!m_run) begin
            m_done = start && (cnt == 0);
            if (start && cnt != 0) begin
                m_run = 1; m_addr = base; m_rem = int'(cnt); m_ovf = 0; m_q.delete();
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
                m_limit = limit; m_berr = 0;
`endif
            end
        end else begin
            m_done = 0;
            if (pop) begin
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
                if (m_addr > m_limit) m_berr = 1;
`endif
                void'(m_q.pop_front());
                m_addr = m_addr + 8'd1;
                m_rem--;
            end
            if (valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(data);
                else m_ovf = 1;
            end
            if (pop && m_rem == 0) begin
                m_run = 0; m_done = 1; m_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((m_run || m_done) && k < max) begin
            cycle();
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, expected 0", busy, k);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [CW-1:0] c);
        base = b; cnt = c; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [AW-1:0] b, input int n);
        logic [AW-1:0] ea;
        n_vec++;
        if (wlog.size() != n) begin
            n_err++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, wlog.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                ea = b + AW'(i);
                n_vec++;
                if (wlog[i] !== {ea, d[i]}) begin
                    n_err++;
                    $display("FAIL %s_word%0d: got %h expected %h", name, i, wlog[i], {ea, d[i]});
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 0; start = 0; valid = 0; ready = 0; base = '0; cnt = '0; data = '0;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        limit = '1;
`endif
        @(posedge clk);
        #1;
        cycle();
        n_vec++;
        if ({wr_en, addr, wdata, busy, done, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", {wr_en, addr, wdata, busy, done, ovf});
        end
        nrst = 1;
        cycle();
    endtask

    task automatic test_basic();
        wlog.delete();
        ready = 1;
        start_job(8'h10, 8'd4);
        for (int i = 0; i < 4; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            cycle();
        end
        valid = 0;
        wait_idle(20);
        check_log("basic", 8'h10, 4);
    endtask

    task automatic test_stall();
        wlog.delete();
        ready = 1;
        start_job(8'h10, 8'd4);
        for (int i = 0; i < 8; i++) begin
            valid = (i < 4);
            data  = DW'($urandom);
            if (i < 4) d[i] = data;
            ready = !(i >= 1 && i <= 3);
            cycle();
        end
        valid = 0; ready = 1;
        wait_idle(20);
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL stall_overflow: got %b expected 0", ovf);
        end
        check_log("stall", 8'h10, 4);
    endtask

    task automatic test_overflow();
        logic [AW-1:0] b;
        b = AW'($urandom);
        wlog.delete();
        ready = 0;
        start_job(b, 8'd8);
        for (int i = 0; i < 6; i++) begin
            valid = 1; data = DW'($urandom);
            if (i < 4) d[i] = data;
            cycle();
        end
        valid = 0; ready = 1;
        for (int i = 0; i < 6; i++) cycle();
        n_vec++;
        if (ovf !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flags: got ovf=%b busy=%b expected ovf=1 busy=1", ovf, busy);
        end
        check_log("overflow", b, 4);
        for (int i = 4; i < 8; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            cycle();
        end
        valid = 0;
        wait_idle(20);
        check_log("overflow_resume", b, 8);
    endtask

    task automatic test_wrap();
        wlog.delete();
        ready = 1;
        start_job(8'hFE, 8'd3);
        for (int i = 0; i < 3; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            cycle();
        end
        valid = 0;
        wait_idle(20);
        check_log("wrap", 8'hFE, 3);
        n_vec++;
        if (wlog.size() == 3 && wlog[2][AW+DW-1:DW] !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_addr: got %h expected 00", wlog[2][AW+DW-1:DW]);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        wlog.delete();
        ready = 1;
        start_job(8'h33, 8'd0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_cnt_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        cycle();
        cycle();
        n_vec++;
        if (wlog.size() != 0) begin
            n_err++;
            $display("FAIL zero_cnt_writes: got %0d expected 0", wlog.size());
        end
        start_job(8'h40, 8'd5);
        for (int i = 0; i < 5; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            if (i == 2) begin base = 8'h80; cnt = 8'd1; start = 1; end
            cycle();
            start = 0;
        end
        valid = 0;
        wait_idle(20);
        check_log("ignored_start", 8'h40, 5);
    endtask

    task automatic test_reset_mid_job();
        int k = 0;
        wlog.delete();
        ready = 1;
        start_job(8'h10, 8'd4);
        while (wlog.size() < 2 && k < 10) begin
            valid = 1; data = DW'($urandom);
            cycle();
            k++;
        end
        nrst = 0; valid = 1;
        cycle();
        n_vec++;
        if ({wr_en, addr, wdata, busy, done, ovf} !== '0) begin
            n_err++;
            $display("FAIL midjob_reset: got %h expected 0", {wr_en, addr, wdata, busy, done, ovf});
        end
        nrst = 1; valid = 0;
        cycle();
        n_vec++;
        if (wlog.size() != 2) begin
            n_err++;
            $display("FAIL midjob_writes: got %0d expected 2", wlog.size());
        end
        wlog.delete();
        start_job(8'h20, 8'd2);
        for (int i = 0; i < 2; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            cycle();
        end
        valid = 0;
        wait_idle(20);
        check_log("after_reset", 8'h20, 2);
    endtask

`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
    task automatic test_bound();
        wlog.delete();
        ready = 1; limit = 8'h11;
        start_job(8'h10, 8'd4);
        limit = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            valid = 1; data = DW'($urandom); d[i] = data;
            cycle();
        end
        valid = 0;
        wait_idle(20);
        check_log("bound", 8'h10, 2);
        n_vec++;
        if (berr !== 1'b1) begin
            n_err++;
            $display("FAIL bound_err_sticky: got %b expected 1", berr);
        end
    endtask
`endif

    task automatic test_random();
        int k;
        for (int j = 0; j < 8; j++) begin
            start_job(AW'($urandom), CW'($urandom_range(1, 12)));
            k = 0;
            while (m_run && k < 400) begin
                valid = ($urandom_range(0, 3) != 0);
                ready = ($urandom_range(0, 2) != 0);
                data  = DW'($urandom);
                start = ($urandom_range(0, 7) == 0);
                cnt   = CW'($urandom);
                base  = AW'($urandom);
                cycle();
                k++;
            end
            start = 0; valid = 0; ready = 1;
            wait_idle(20);
        end
    endtask

    initial begin
        m_run = 0; m_done = 0; m_ovf = 0; m_addr = '0; m_rem = 0;
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        m_limit = '0; m_berr = 0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_wrap();
        test_zero_and_ignored_start();
        test_reset_mid_job();
`ifdef OUTPUT_SPAD_WRITER_BOUND_CHECK_EN
        test_bound();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/output_spad_writer.md
# output_spad_writer

Sits directly downstream of the output router. It takes the packed SPAD-width words the router emits (one word per cycle while valid) and writes them into the output scratchpad at consecutive addresses starting from a programmed base. A small FIFO absorbs stalls from the shared SPAD write port, because the router has no backpressure. The block signals completion once a programmed number of words has been committed.

## Interface
Parameters:
- SPAD_ADDR_WIDTH, default 8: output SPAD address width.
- SPAD_DATA_WIDTH, default 16: word width; equals router output width.
- CNT_WIDTH, default 8: width of the word-count field.
- FIFO_DEPTH, default 4: skid FIFO entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_nrst  in  1  reset; synchronous, active-low.
- i_start  in  1  one-cycle job start; honoured only in IDLE.
- i_base_addr  in  SPAD_ADDR_WIDTH  first write address; sampled on accepted i_start.
- i_word_cnt  in  CNT_WIDTH  words to commit; sampled on accepted i_start.
- i_data  in  SPAD_DATA_WIDTH  packed word from router.
- i_valid  in  1  i_data valid this cycle.
- i_spad_wr_ready  in  1  SPAD write port granted this cycle.
- o_spad_wr_en  out  1  write strobe.
- o_spad_addr  out  SPAD_ADDR_WIDTH  write address.
- o_spad_data  out  SPAD_DATA_WIDTH  write data.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse when the job completes.
- o_overflow  out  1  sticky; a word was dropped because the FIFO was full.
- i_addr_limit  in  SPAD_ADDR_WIDTH  highest legal address; present only with the macro below.
- o_bound_err  out  1  sticky; present only with the macro below.

## Operation
- States: IDLE and RUN.
- IDLE → RUN on i_start with i_word_cnt≠0.
  - Load addr=i_base_addr and remaining=i_word_cnt.
  - Flush the FIFO.
  - Clear o_overflow and o_bound_err.
- i_start with i_word_cnt=0: stay IDLE, pulse o_done the next cycle, no writes.
- i_start while in RUN is ignored.
- RUN, push: an i_valid word is pushed to the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and o_overflow is set.
  - Push and pop in the same cycle on a full FIFO is legal and drops nothing.
- RUN, pop: the FIFO head is popped when the FIFO is not empty and i_spad_wr_ready=1.
  - o_spad_wr_en=1, o_spad_addr=addr, o_spad_data=head.
  - addr increments modulo 2^SPAD_ADDR_WIDTH (wraps silently).
  - remaining decrements.
- Completion: the pop that takes remaining 1→0 returns the block to IDLE the next cycle with a one-cycle o_done pulse.
  - Leftover FIFO contents are discarded.
- In IDLE, i_valid words are ignored and the FIFO stays empty.
- o_spad_wr_en is combinational: state==RUN && !empty && i_spad_wr_ready. o_spad_addr and o_spad_data are 0 whenever o_spad_wr_en=0.

## Timing
- Reset values: state=IDLE, FIFO empty, all outputs 0, addr=0, remaining=0.
- Reset mid-job aborts immediately. No write strobe is asserted during or after the reset cycle.
- Latency: a word with i_valid in cycle N can be written in cycle N+1 at the earliest (registered FIFO).
- Throughput: one word per cycle while i_spad_wr_ready stays high.
- i_start accepted in cycle N → o_busy=1 from N+1, and words with i_valid in N+1 are accepted.
- Final write in cycle M → o_done=1 and o_busy=0 in cycle M+1.

## Configuration
- OUTPUT_SPAD_WRITER_BOUND_CHECK_EN defined:
  - Adds i_addr_limit (sampled at start) and o_bound_err.
  - A pop whose addr > limit is not written (o_spad_wr_en=0), but the word is still consumed and remaining still decrements.
  - o_bound_err is set on such a pop.
- Macro undefined: the ports are absent and the address wraps with no check.

## Structure
- Shared package output_path_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - the localparam FIFO_PTR_W = $clog2(FIFO_DEPTH).
- One sub-module, osw_sync_fifo: parameterised width/depth, push/pop/full/empty/flush, synchronous active-low reset.

## Test plan
- Basic job: base=0x10, cnt=4, ready=1, four consecutive valid words A..D → writes 0x10..0x13 in cycles N+1..N+4; o_done one cycle after the last write.
- Stall: same job with ready low for 3 cycles mid-burst, FIFO_DEPTH=4 → no drop, o_overflow=0, addresses still contiguous and data in order.
- Overflow: ready=0 with 6 valid words pushed → the 5th and 6th are dropped and o_overflow=1; on releasing ready, 4 words are written and the job stays in RUN awaiting more.
- Address wrap: base=0xFE, cnt=3 → writes at 0xFE, 0xFF, 0x00.
- Zero count and ignored start: cnt=0 → o_done pulse with no writes; a second i_start during RUN does not change addr or remaining.
- Reset mid-job: i_nrst low after 2 of 4 writes → all outputs 0, next start behaves as from reset; with the macro, limit=0x11 and base=0x10, cnt=4 → only 2 writes and o_bound_err=1.
